// File: rtl/pingpong_fft_feeder.sv
// -----------------------------------------------------------------------------
// pingpong_fft_feeder
//
// Reads one full frame at a time from the read (B) side of a ping-pong sample
// buffer and streams it into a Xilinx FFT core as complex AXI4-Stream beats.
// After reset it sends a single FFT configuration word. A small skid FIFO
// covers the RAM read latency and output backpressure, so reads are throttled
// and a stalled consumer never loses or duplicates a sample.
//
// Ports:
//   clk                   single clock, shared with the buffer's B side
//   rst                   synchronous active-high reset (also the buffer's rstb)
//   addrb       [ADDR_W]  read address into the buffer
//   doutb       [DATA_W]  read data, valid RD_LAT cycles after addrb
//   readyb                buffer reports a full frame is readable
//   finishb               one-cycle pulse: frame consumed, swap sector
//   m_axis_config_*       FFT configuration channel (tdata/tvalid/tready)
//   m_axis_data_*         FFT data channel, tdata = {imag=0, real=sample}
//   busy                  high in every state except IDLE
//   frame_count [16]      finished-frame counter, only with FEEDER_FRAME_CNT_EN
//
// Build option: define FEEDER_FRAME_CNT_EN to add the frame_count output.
//
// FIFO_DEPTH must be at least RD_LAT+2 to sustain one beat per cycle.
// -----------------------------------------------------------------------------
module pingpong_fft_feeder #(
    parameter int               ADDR_W     = 7,
    parameter int               DATA_W     = 16,
    parameter int               RD_LAT     = 1,
    parameter int               FIFO_DEPTH = 4,
    parameter int               CFG_W      = 8,
    parameter logic [CFG_W-1:0] CFG_WORD   = 8'h01
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   addrb,
    input  logic [DATA_W-1:0]   doutb,
    input  logic                readyb,
    output logic                finishb,
    output logic [CFG_W-1:0]    m_axis_config_tdata,
    output logic                m_axis_config_tvalid,
    input  logic                m_axis_config_tready,
    output logic [2*DATA_W-1:0] m_axis_data_tdata,
    output logic                m_axis_data_tvalid,
    input  logic                m_axis_data_tready,
    output logic                m_axis_data_tlast,
    output logic                busy
`ifdef FEEDER_FRAME_CNT_EN
    ,
    output logic [15:0]         frame_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_CFG,
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                fin_q, fin_d;
    logic                cfg_vld_q, cfg_vld_d;
    logic                busy_q, busy_d;
    logic                skip_q, skip_d;     // ignore readyb for one IDLE cycle

    // Read-latency shadow pipe: tracks which RAM outputs are real samples.
    logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0]   last_pipe_q, last_pipe_d;

    // Skip FIFO storage plus a registered copy of its head for the outputs.
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic                fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                out_vld_q, out_vld_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;

    logic                issue;
    logic                push;
    logic                pop;
    int                  inflight;

    // -------------------------------------------------------------------------
    // Control FSM: next state, read issue and registered control outputs.
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        skip_d   = 1'b0;
        issue    = 1'b0;
        pop      = out_vld_q && m_axis_data_tready;
        push     = vld_pipe_q[RD_LAT-1];
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + int'(vld_pipe_q[i]);
        end

        case (state_q)
            S_CFG: begin
                if (cfg_vld_q && m_axis_config_tready) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (readyb && !skip_q) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Reserve a FIFO slot for every read still in the RAM pipe so
                // a stalled consumer can never overflow the FIFO.
                if (int'(count_q) + inflight < FIFO_DEPTH) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;   // wraps to 0 after the last read
                    if (addr_q == '1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The tlast beat is the only one left once it handshakes.
                if (pop && out_last_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                skip_d  = 1'b1;   // buffer drops readyb on this same edge
            end
            default: state_d = S_CFG;
        endcase

        cfg_vld_d = (state_d == S_CFG);
        fin_d     = (state_d == S_FINISH);
        busy_d    = (state_d != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // Read pipe and skid FIFO next state.
    // -------------------------------------------------------------------------
    always_comb begin
        vld_pipe_d     = '0;
        last_pipe_d    = '0;
        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue && (addr_q == '1);
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // Registered head: pick the entry that will sit at rd_ptr next cycle,
        // bypassing the storage when that entry is being written right now.
        // An unpopped head keeps its value, which holds tdata/tlast on stalls.
        out_vld_d  = (count_d != '0);
        out_data_d = out_data_q;
        out_last_d = 1'b0;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                out_data_d = doutb;
                out_last_d = last_pipe_q[RD_LAT-1];
            end else begin
                out_data_d = fifo_data_q[rd_ptr_d];
                out_last_d = fifo_last_q[rd_ptr_d];
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CFG;
            addr_q      <= '0;
            fin_q       <= 1'b0;
            cfg_vld_q   <= 1'b0;
            busy_q      <= 1'b1;
            skip_q      <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            fin_q       <= fin_d;
            cfg_vld_q   <= cfg_vld_d;
            busy_q      <= busy_d;
            skip_q      <= skip_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count define which
    // entries are live, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= doutb;
            fifo_last_q[wr_ptr_q] <= last_pipe_q[RD_LAT-1];
        end
    end

`ifdef FEEDER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (fin_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;   // wraps 0xFFFF -> 0
        end
    end

    assign frame_count = frame_cnt_q;
`else
    // No frame counter in this build.
`endif

    assign addrb                = addr_q;
    assign finishb              = fin_q;
    assign busy                 = busy_q;
    assign m_axis_config_tdata  = CFG_WORD;
    assign m_axis_config_tvalid = cfg_vld_q;
    assign m_axis_data_tvalid   = out_vld_q;
    assign m_axis_data_tlast    = out_last_q;
    assign m_axis_data_tdata    = {{DATA_W{1'b0}}, out_data_q};

endmodule

// File: tb/tb_pingpong_fft_feeder.sv
// -----------------------------------------------------------------------------
// tb_pingpong_fft_feeder
//
// Self-checking bench for pingpong_fft_feeder with default parameters.
// A behavioural RAM returns sample = addr + ram_base one cycle after addrb.
// Expected beats are queued when a frame is made ready and compared as the
// DUT presents them; a table of frame runs covers several tready patterns and
// hand-written sequences cover config, stalls, back-to-back and reset.
// -----------------------------------------------------------------------------
module tb_pingpong_fft_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  addrb;
    logic [15:0] doutb;
    logic        readyb;
    logic        finishb;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [31:0] data_tdata;
    logic        data_tvalid;
    logic        data_tready;
    logic        data_tlast;
    logic        busy;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          mode;       // tready pattern
        logic [15:0] base;       // RAM sample offset
        int          exp_lat;    // cycles from readyb sample to first tvalid
        int          exp_beats;
        bit          gapless;
    } vec_t;

    beat_t       sb[$];
    vec_t        vecs[3];
    int          total = 0;
    int          bad   = 0;
    int          mode  = 0;
    int          pat_i = 0;
    int          cyc   = 0;
    int          beats = 0;
    int          fin_cnt = 0;
    int          fin_cyc = 0;
    int          first_cyc = -1;
    int          last_cyc  = -1;
    bit          stall_prev = 1'b0;
    logic [15:0] ram_base = 16'h0100;

    pingpong_fft_feeder dut (
        .clk                  (clk),
        .rst                  (rst),
        .addrb                (addrb),
        .doutb                (doutb),
        .readyb               (readyb),
        .finishb              (finishb),
        .m_axis_config_tdata  (cfg_tdata),
        .m_axis_config_tvalid (cfg_tvalid),
        .m_axis_config_tready (cfg_tready),
        .m_axis_data_tdata    (data_tdata),
        .m_axis_data_tvalid   (data_tvalid),
        .m_axis_data_tready   (data_tready),
        .m_axis_data_tlast    (data_tlast),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency RAM model.
    always @(posedge clk) doutb <= 16'(addrb) + ram_base;

    // tready pattern driver; #2 keeps it clear of mode changes made at #1.
    always @(posedge clk) begin
        #2;
        pat_i = pat_i + 1;
        case (mode)
            0:       data_tready = 1'b1;
            1:       data_tready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
            2:       data_tready = ($urandom_range(0, 2) != 0);
            default: data_tready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: every valid beat is compared with the scoreboard head,
    // which also proves data stays put while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("valid_held_in_stall", data_tvalid, 1);
            if (data_tvalid) begin
                check("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    check("beat", {data_tdata, data_tlast}, sb[0]);
                    if (data_tready) begin
                        void'(sb.pop_front());
                        beats = beats + 1;
                        if (first_cyc < 0) first_cyc = cyc;
                        if (data_tlast) last_cyc = cyc;
                    end
                end
            end
            stall_prev = data_tvalid && !data_tready;
            if (finishb) begin
                fin_cnt = fin_cnt + 1;
                fin_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        beats     = 0;
        fin_cnt   = 0;
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    task automatic push_frame(input logic [15:0] base);
        beat_t b;
        for (int i = 0; i < 128; i++) begin
            b.data = {16'h0000, base + 16'(i)};
            b.last = (i == 127);
            sb.push_back(b);
        end
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 2000 && beats < n; i++) @(posedge clk);
        check("beats_reached", beats >= n, 1);
    endtask

    task automatic wait_fin(input int n);
        for (int i = 0; i < 3000 && fin_cnt < n; i++) @(posedge clk);
        check("finish_seen", fin_cnt >= n, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addrb"}, addrb, 0);
        check({tag, "_finishb"}, finishb, 0);
        check({tag, "_cfg_tvalid"}, cfg_tvalid, 0);
        check({tag, "_tvalid"}, data_tvalid, 0);
        check({tag, "_tlast"}, data_tlast, 0);
        check({tag, "_tdata"}, data_tdata, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic run_frame(input vec_t v);
        int lat;
        clear_stats();
        mode     = v.mode;
        ram_base = v.base;
        push_frame(v.base);
        @(posedge clk);
        #1 readyb = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (data_tvalid) lat = k;
        end
        check("first_valid_latency", lat, v.exp_lat);
        wait_fin(1);
        #1 readyb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("frame_finish_count", fin_cnt, 1);
        check("frame_beats", beats, v.exp_beats);
        check("frame_sb_empty", sb.size(), 0);
        check("finish_after_tlast", fin_cyc, last_cyc + 1);
        check("frame_idle_busy", busy, 0);
        if (v.gapless) check("gapless_span", last_cyc - first_cyc, 127);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mode: 0, base: 16'h0100, exp_lat: 3, exp_beats: 128, gapless: 1'b1};
        vecs[1] = '{mode: 1, base: 16'h0100, exp_lat: 3, exp_beats: 128, gapless: 1'b0};
        vecs[2] = '{mode: 2, base: 16'h0300, exp_lat: 3, exp_beats: 128, gapless: 1'b0};

        rst         = 1'b1;
        readyb      = 1'b0;
        cfg_tready  = 1'b1;
        data_tready = 1'b1;

        // Reset and configuration handshake.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        check("cfg_tdata", cfg_tdata, 8'h01);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("cfg_valid_first", cfg_tvalid, 1);
        check("cfg_busy_first", busy, 1);
        check("cfg_word", cfg_tdata, 8'h01);
        @(posedge clk);
        @(negedge clk);
        check("cfg_valid_dropped", cfg_tvalid, 0);
        check("cfg_busy_dropped", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cfg_valid_once", cfg_tvalid, 0);

        // Table of single frames under different tready patterns.
        for (int v = 0; v < 3; v++) begin
            run_frame(vecs[v]);
        end

        // Long stall mid-frame: reads stop once four samples are outstanding.
        clear_stats();
        mode     = 0;
        ram_base = 16'h0700;
        push_frame(16'h0700);
        @(posedge clk);
        #1 readyb = 1'b1;
        wait_beats(40);
        #1 mode = 3;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("stall_addrb_frozen", addrb, 7'(beats + 4));
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("stall_addrb_still", addrb, 7'(beats + 4));
        check("stall_tvalid", data_tvalid, 1);
        mode = 0;
        wait_fin(1);
        #1 readyb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_beats", beats, 128);
        check("stall_sb_empty", sb.size(), 0);
        check("stall_finish_count", fin_cnt, 1);

        // Back-to-back frames with readyb held high through FINISH.
        clear_stats();
        ram_base = 16'h0500;
        push_frame(16'h0500);
        @(posedge clk);
        #1 readyb = 1'b1;
        wait_fin(1);
        #1 ram_base = 16'h0600;
        push_frame(16'h0600);
        @(negedge clk);
        check("b2b_idle_after_finish", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_no_early_restart", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_restart", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_tvalid_before", data_tvalid, 0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_tvalid_first", data_tvalid, 1);
        wait_fin(2);
        #1 readyb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("b2b_beats", beats, 256);
        check("b2b_finish_count", fin_cnt, 2);
        check("b2b_sb_empty", sb.size(), 0);

        // Reset at beat 60: no finishb, config repeats, next frame from 0.
        clear_stats();
        ram_base = 16'h0900;
        push_frame(16'h0900);
        @(posedge clk);
        #1 readyb = 1'b1;
        wait_beats(60);
        #1 rst = 1'b1;
        cfg_tready = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midrst");
        repeat (2) @(posedge clk);
        check("midrst_no_finish", fin_cnt, 0);
        clear_stats();
        push_frame(16'h0900);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_cfg_wait", cfg_tvalid, 1);
            check("midrst_busy_cfg", busy, 1);
            check("midrst_readyb_ignored", data_tvalid, 0);
        end
        @(posedge clk);
        #1 cfg_tready = 1'b1;
        wait_fin(1);
        #1 readyb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_beats", beats, 128);
        check("midrst_sb_empty", sb.size(), 0);
        check("midrst_finish_count", fin_cnt, 1);
        check("midrst_cfg_done", cfg_tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pingpong_fft_feeder.md
Name: pingpong_fft_feeder

Overview:
- Downstream consumer of the ping-pong sample buffer's read (B) side.
- Waits for a full 128-sample frame to be ready, then reads it address by address.
- Absorbs the RAM read latency and output backpressure in a small skid FIFO.
- Streams the samples as complex AXI4-Stream beats into the Xilinx FFT core, then pulses finishb to hand the sector back. After reset it also issues one FFT configuration word.

Parameters:
- ADDR_W, 7, frame address width; frame length = 2**ADDR_W.
- DATA_W, 16, sample width.
- RD_LAT, 1, RAM read latency in cycles from addrb to doutb; legal values 1 or 2.
- FIFO_DEPTH, 4, skid FIFO entries; must be >= RD_LAT+2.
- CFG_W, 8, FFT config word width.
- CFG_WORD, 8'h01, config word sent once after reset (bit0=1 selects forward FFT).

Ports:
- clk  in  1  single clock, shared with the buffer's B side.
- rst  in  1  synchronous active-high reset; also drives the buffer's rstb.
- addrb  out  ADDR_W  read address into the buffer.
- doutb  in  DATA_W  read data from the buffer.
- readyb  in  1  buffer reports a full frame is readable.
- finishb  out  1  one-cycle pulse: frame consumed, swap sector.
- m_axis_config_tdata  out  CFG_W  FFT config word.
- m_axis_config_tvalid  out  1  config valid.
- m_axis_config_tready  in  1  config ready.
- m_axis_data_tdata  out  2*DATA_W  {imag=0, real=sample}.
- m_axis_data_tvalid  out  1  data valid.
- m_axis_data_tready  in  1  data ready.
- m_axis_data_tlast  out  1  marks the last sample of a frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: addrb=0, finishb=0, m_axis_config_tvalid=0, m_axis_data_tvalid=0, m_axis_data_tlast=0, m_axis_data_tdata=0, busy=1 (state CFG). The FIFO is emptied and the in-flight pipe cleared.
- States: CFG -> IDLE -> READ -> DRAIN -> FINISH -> IDLE.
- CFG:
  - tdata=CFG_WORD; config tvalid=1 from the first cycle after rst deasserts.
  - Leave to IDLE on the cycle config tvalid&tready is sampled.
  - readyb is ignored while in CFG.
- IDLE:
  - readyb=1 sampled -> READ, with addrb=0 presented in the next cycle.
- READ:
  - A read is issued in a cycle when fifo_count + inflight < FIFO_DEPTH. When stalled, addrb holds.
  - An issued read enters a RD_LAT-deep valid/last shift pipe; last=1 for address 2**ADDR_W-1.
  - doutb is written to the FIFO when the pipe output is valid.
  - After the read of address 2**ADDR_W-1 is issued -> DRAIN; addrb wraps to 0.
- DRAIN: once the FIFO and pipe are empty and the tlast beat handshakes -> FINISH.
- FINISH:
  - finishb=1 for exactly one cycle, then -> IDLE.
  - IDLE must not restart in the cycle after FINISH even if readyb is still seen high; the buffer clears readyb on the same edge, and the feeder ignores readyb for that one cycle.
- Data output:
  - tvalid=1 whenever the FIFO is non-empty; tdata = {DATA_W'b0, sample}.
  - tdata, tvalid and tlast stay stable while tvalid&&!tready.
- Latency: readyb sampled in cycle T -> first tvalid in cycle T+RD_LAT+2.
- Throughput: with tready=1 continuously, 2**ADDR_W consecutive beats with no bubbles, and finishb in the cycle after the tlast handshake.
- FIFO never overflows or underflows for any tready pattern.
- Only one frame is in progress at a time; addrb is never advanced outside READ.
- Reset mid-frame: immediate return to reset state with no finishb pulse. The partial frame is discarded downstream by FFT reset, which is the system's responsibility.

Optional Feature:
- Macro FEEDER_FRAME_CNT_EN.
- When defined: adds output frame_count [15:0]. It resets to 0, increments by 1 on each finishb pulse, and wraps 0xFFFF->0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles, then config_tready=1 -> config tvalid for exactly 1 cycle with tdata=8'h01; busy drops to 0 the next cycle.
- Frame with RAM preloaded sample=addr+16'h100, tready=1, RD_LAT=1 -> first tvalid 3 cycles after readyb; 128 gapless beats tdata=32'h0000_0100..32'h0000_017F; tlast only on beat 128; one finishb pulse.
- Same frame with tready toggling 1,0,0,1 repeating -> identical ordered data; no duplicates or drops; tdata stable across stalls; FIFO count never exceeds 4.
- tready held 0 for 50 cycles mid-frame -> addrb freezes after FIFO fills; resumes correctly after release.
- Two frames back-to-back with readyb re-asserting 2 cycles after finishb -> second frame starts; no spurious restart in the cycle after FINISH.
- rst asserted at beat 60 -> outputs return to reset values next cycle; no finishb; CFG handshake repeats; the next frame starts from addrb=0.
